gigatron_input_arbiter: RTL and testbench

- Emulates the Famicom serial controller that the Gigatron core polls through famicom_latch, famicom_pulse and famicom_data.
- Shares that single serial input between two requesters:
  - the MiSTer joystick, a level source;
  - a keyboard ASCII stream, a valid/ready source.
- A keyboard byte is presented for a fixed number of frames, followed by an idle gap, so the Gigatron sees each keypress once.
- Sits in emu between hps_io and Gigatron_Shell, in the clk_sys domain.

---
 rtl/gigatron_input_pkg.sv | 28 ++
 rtl/sync_edge_detect.sv | 29 ++
 rtl/gigatron_input_arbiter.sv | 132 +++++++++++++
 tb/tb_gigatron_input_arbiter.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/gigatron_input_pkg.sv
// Shared types and constants for the Gigatron Famicom-controller input arbiter.
package gigatron_input_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      KEY_HOLD = 2'd1,
      KEY_GAP  = 2'd2
   } arb_state_e;

   // The Famicom pad is active-low on the wire: all ones means nothing pressed.
   localparam logic [7:0] BUTTONS_IDLE = 8'hFF;

   localparam int BTN_RIGHT  = 0;
   localparam int BTN_LEFT   = 1;
   localparam int BTN_DOWN   = 2;
   localparam int BTN_UP     = 3;
   localparam int BTN_START  = 4;
   localparam int BTN_SELECT = 5;
   localparam int BTN_B      = 6;
   localparam int BTN_A      = 7;

   localparam int FRAME_CNT_W = 4;

   function automatic logic [7:0] joy_to_serial(input logic [7:0] joy);
      return ~joy;
   endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchronizer for an asynchronous strobe plus a one-cycle rising-edge pulse.
module sync_edge_detect (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic async_i,
   output logic sync_o,
   output logic rise_o
);

   logic meta_q;
   logic sync_q;
   logic hist_q;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
         hist_q <= 1'b0;
      end else begin
         meta_q <= async_i;
         sync_q <= meta_q;
         hist_q <= sync_q;
      end
   end

   assign sync_o = sync_q;
   assign rise_o = sync_q & ~hist_q;

endmodule

// File: rtl/gigatron_input_arbiter.sv
// Famicom serial-pad emulation shared between the MiSTer joystick and a keyboard
// ASCII stream; each key is presented for HOLD_FRAMES captures, then GAP_FRAMES of idle.
module gigatron_input_arbiter
   import gigatron_input_pkg::*;
#(
   parameter int HOLD_FRAMES = 2,
   parameter int GAP_FRAMES  = 1
) (
   input  logic       clk_sys,
   input  logic       reset_n,
   input  logic [7:0] joy,
   input  logic       kbd_valid,
   input  logic [7:0] kbd_data,
   output logic       kbd_ready,
   input  logic       famicom_latch,
   input  logic       famicom_pulse,
   output logic       famicom_data,
   output logic       kbd_busy
);

   localparam logic [FRAME_CNT_W-1:0] HOLD_INIT = FRAME_CNT_W'(HOLD_FRAMES);
   localparam logic [FRAME_CNT_W-1:0] GAP_INIT  = FRAME_CNT_W'(GAP_FRAMES);
   localparam logic [FRAME_CNT_W-1:0] CNT_ONE   = FRAME_CNT_W'(1);

   logic latch_sync;
   logic latch_rise;
   logic pulse_rise;
   logic pulse_lvl_unused;

   arb_state_e             state_q, state_d;
   logic [7:0]             sh_q, sh_d;
   logic [7:0]             key_q, key_d;
   logic [FRAME_CNT_W-1:0] hold_cnt_q, hold_cnt_d;
   logic [FRAME_CNT_W-1:0] gap_cnt_q, gap_cnt_d;
   logic [7:0]             src_byte;
   logic                   handshake;

   sync_edge_detect u_latch_sync (
      .clk_i  (clk_sys),
      .rst_ni (reset_n),
      .async_i(famicom_latch),
      .sync_o (latch_sync),
      .rise_o (latch_rise)
   );

   sync_edge_detect u_pulse_sync (
      .clk_i  (clk_sys),
      .rst_ni (reset_n),
      .async_i(famicom_pulse),
      .sync_o (pulse_lvl_unused),
      .rise_o (pulse_rise)
   );

   assign kbd_ready    = reset_n && (state_q == IDLE);
   assign kbd_busy     = reset_n && (state_q != IDLE);
   assign famicom_data = sh_q[7];
   assign handshake    = kbd_valid && kbd_ready;

   always_comb begin
      src_byte = BUTTONS_IDLE;
      case (state_q)
         IDLE:     src_byte = joy_to_serial(joy);
         KEY_HOLD: src_byte = key_q;
         default:  src_byte = BUTTONS_IDLE;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      sh_d       = sh_q;
      key_d      = key_q;
      hold_cnt_d = hold_cnt_q;
      gap_cnt_d  = gap_cnt_q;

      // A latch edge always reloads; clocks are only honoured once the latch is low.
      if (latch_rise) begin
         sh_d = src_byte;
      end else if (pulse_rise && !latch_sync) begin
         sh_d = {sh_q[6:0], 1'b1};
      end

      case (state_q)
         IDLE: begin
            if (handshake) begin
               key_d      = kbd_data;
               hold_cnt_d = HOLD_INIT;
               state_d    = KEY_HOLD;
            end
         end
         KEY_HOLD: begin
            if (latch_rise) begin
               hold_cnt_d = hold_cnt_q - CNT_ONE;
               if (hold_cnt_q <= CNT_ONE) begin
                  hold_cnt_d = '0;
                  gap_cnt_d  = GAP_INIT;
                  state_d    = KEY_GAP;
               end
            end
         end
         KEY_GAP: begin
            if (latch_rise) begin
               gap_cnt_d = gap_cnt_q - CNT_ONE;
               if (gap_cnt_q <= CNT_ONE) begin
                  gap_cnt_d = '0;
                  state_d   = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_sys) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         sh_q       <= BUTTONS_IDLE;
         hold_cnt_q <= '0;
         gap_cnt_q  <= '0;
      end else begin
         state_q    <= state_d;
         sh_q       <= sh_d;
         hold_cnt_q <= hold_cnt_d;
         gap_cnt_q  <= gap_cnt_d;
      end
   end

   // The key byte is only meaningful outside IDLE, so it needs no reset.
   always_ff @(posedge clk_sys) begin
      key_q <= key_d;
   end

endmodule

// File: tb/tb_gigatron_input_arbiter.sv
// Self-checking bench for gigatron_input_arbiter: frame table plus hand-written reset sequence.
module tb_gigatron_input_arbiter;

   logic       clk_sys = 1'b0;
   logic       reset_n;
   logic [7:0] joy;
   logic       kbd_valid;
   logic [7:0] kbd_data;
   logic       kbd_ready;
   logic       famicom_latch;
   logic       famicom_pulse;
   logic       famicom_data;
   logic       kbd_busy;

   int checks = 0;
   int errors = 0;
   logic [7:0] exp_q[$];

   typedef struct {
      logic [7:0] joy;
      logic       kv;
      logic [7:0] kd;
      int         mode;
      logic [7:0] exp;
      logic       rdy;
      logic       busy;
   } vec_t;

   vec_t vecs[11];

   always #5 clk_sys = ~clk_sys;

   gigatron_input_arbiter #(.HOLD_FRAMES(2), .GAP_FRAMES(1)) dut (
      .clk_sys      (clk_sys),
      .reset_n      (reset_n),
      .joy          (joy),
      .kbd_valid    (kbd_valid),
      .kbd_data     (kbd_data),
      .kbd_ready    (kbd_ready),
      .famicom_latch(famicom_latch),
      .famicom_pulse(famicom_pulse),
      .famicom_data (famicom_data),
      .kbd_busy     (kbd_busy)
   );

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h, want %h", nm, act, req);
      end
   endtask

   task automatic chkb(input string nm, input logic act, input logic req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %b, want %b", nm, act, req);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk_sys);
   endtask

   task automatic clk_pulse();
      famicom_pulse = 1'b1;
      cyc(4);
      famicom_pulse = 1'b0;
      cyc(4);
   endtask

   task automatic do_handshake(input logic [7:0] d, input string nm);
      chkb({nm, " ready before"}, kbd_ready, 1'b1);
      kbd_data  = d;
      kbd_valid = 1'b1;
      cyc(1);
      kbd_valid = 1'b0;
      chkb({nm, " ready dropped"}, kbd_ready, 1'b0);
      chkb({nm, " busy set"}, kbd_busy, 1'b1);
   endtask

   // mode 0 normal, 1 handshake lands on the latch-rise cycle,
   // 2 pulse rises together with latch, 3 extra pulse while latch is high.
   task automatic run_frame(input logic [7:0] exp, input int mode, input string nm);
      logic [7:0] got;
      logic       ones;
      exp_q.push_back(exp);
      famicom_latch = 1'b1;
      if (mode == 2) famicom_pulse = 1'b1;
      cyc(2);
      chkb({nm, " data before 3cyc"}, famicom_data, 1'b1);
      if (mode == 1) kbd_valid = 1'b1;
      cyc(1);
      kbd_valid = 1'b0;
      chkb({nm, " data at 3cyc"}, famicom_data, exp[7]);
      if (mode == 3) clk_pulse();
      cyc(2);
      famicom_latch = 1'b0;
      famicom_pulse = 1'b0;
      cyc(4);
      got[7] = famicom_data;
      for (int i = 6; i >= 0; i--) begin
         clk_pulse();
         got[i] = famicom_data;
      end
      ones = 1'b1;
      repeat (3) begin
         clk_pulse();
         ones = ones & famicom_data;
      end
      chkb({nm, " trailing ones"}, ones, 1'b1);
      chk({nm, " byte"}, got, exp_q.pop_front());
   endtask

   initial begin
      reset_n       = 1'b0;
      joy           = 8'h00;
      kbd_valid     = 1'b0;
      kbd_data      = 8'h00;
      famicom_latch = 1'b0;
      famicom_pulse = 1'b0;

      //          joy    kv    kd     mode exp    rdy   busy
      vecs[0]  = '{8'h81, 1'b0, 8'h00, 0, 8'h7E, 1'b1, 1'b0};
      vecs[1]  = '{8'h00, 1'b1, 8'h41, 0, 8'h41, 1'b0, 1'b1};
      vecs[2]  = '{8'hFF, 1'b0, 8'h00, 0, 8'h41, 1'b0, 1'b1};
      vecs[3]  = '{8'hFF, 1'b0, 8'h00, 0, 8'hFF, 1'b1, 1'b0};
      vecs[4]  = '{8'hFF, 1'b0, 8'h00, 0, 8'h00, 1'b1, 1'b0};
      vecs[5]  = '{8'h81, 1'b0, 8'h00, 2, 8'h7E, 1'b1, 1'b0};
      vecs[6]  = '{8'h01, 1'b0, 8'h5A, 1, 8'hFE, 1'b0, 1'b1};
      vecs[7]  = '{8'h01, 1'b0, 8'h00, 3, 8'h5A, 1'b0, 1'b1};
      vecs[8]  = '{8'h01, 1'b0, 8'h00, 0, 8'h5A, 1'b0, 1'b1};
      vecs[9]  = '{8'h00, 1'b0, 8'h00, 0, 8'hFF, 1'b1, 1'b0};
      vecs[10] = '{8'h10, 1'b0, 8'h00, 0, 8'hEF, 1'b1, 1'b0};

      cyc(3);
      chkb("reset data", famicom_data, 1'b1);
      chkb("reset ready", kbd_ready, 1'b0);
      chkb("reset busy", kbd_busy, 1'b0);
      reset_n = 1'b1;
      #1;
      chkb("ready after reset", kbd_ready, 1'b1);
      cyc(1);

      for (int v = 0; v < 11; v++) begin
         joy      = vecs[v].joy;
         kbd_data = vecs[v].kd;
         if (vecs[v].kv) do_handshake(vecs[v].kd, $sformatf("vec%0d hs", v));
         run_frame(vecs[v].exp, vecs[v].mode, $sformatf("vec%0d", v));
         chkb($sformatf("vec%0d ready", v), kbd_ready, vecs[v].rdy);
         chkb($sformatf("vec%0d busy", v), kbd_busy, vecs[v].busy);
      end

      // Reset in the middle of a key presentation, with the key's MSB (0) on the wire.
      joy = 8'h02;
      do_handshake(8'h33, "rst hs");
      famicom_latch = 1'b1;
      cyc(3);
      chkb("rst key loaded", famicom_data, 1'b0);
      cyc(2);
      famicom_latch = 1'b0;
      cyc(4);
      reset_n = 1'b0;
      cyc(1);
      chkb("rst data", famicom_data, 1'b1);
      chkb("rst busy", kbd_busy, 1'b0);
      chkb("rst ready low", kbd_ready, 1'b0);
      reset_n = 1'b1;
      #1;
      chkb("rst ready first cycle", kbd_ready, 1'b1);
      cyc(1);
      run_frame(8'hFD, 0, "post rst");
      chkb("post rst ready", kbd_ready, 1'b1);
      chkb("post rst busy", kbd_busy, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
